// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// port (I) and the load/store port (D). Only one transaction is outstanding at
// a time. D has fixed priority, but I is forced through after STARVE_MAX
// consecutive D wins. Misaligned requests are answered locally with an error
// and never reach memory.
module mem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        ERR_I,
        ERR_D
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          busy_we, busy_we_nxt;
    logic          sel_d, sel_i;
    logic          i_mis, d_mis;

    assign i_mis = (i_addr[1:0] != 2'b00);
    assign d_mis = (d_addr[1:0] != 2'b00);

    // State, starvation counter and store flag of the outstanding transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy_we    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            busy_we    <= busy_we_nxt;
        end
    end

    // Arbitration, next state and all outputs
    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        busy_we_nxt = busy_we;
        i_gnt       = 1'b0;
        i_rvalid    = 1'b0;
        i_rdata     = '0;
        i_err       = 1'b0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        sel_d       = d_req && !(i_req && (starve_cnt == STARVE_LIM));
        sel_i       = i_req && !sel_d;

        // Outputs are combinational from the requests, so they are held low
        // while resetn is asserted to keep every output at 0 during reset.
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (sel_d) begin
                        if (d_mis) begin
                            d_gnt     = 1'b1;
                            state_nxt = ERR_D;
                        end else begin
                            mem_req   = 1'b1;
                            mem_we    = d_we;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                            mem_wstrb = d_wstrb;
                            d_gnt     = mem_ready;
                            if (mem_ready) begin
                                state_nxt   = BUSY_D;
                                busy_we_nxt = d_we;
                            end
                        end
                        if (d_gnt && i_req && (starve_cnt != STARVE_LIM)) begin
                            starve_nxt = starve_cnt + CW'(1);
                        end
                    end else if (sel_i) begin
                        if (i_mis) begin
                            i_gnt     = 1'b1;
                            state_nxt = ERR_I;
                        end else begin
                            mem_req  = 1'b1;
                            mem_addr = i_addr;
                            i_gnt    = mem_ready;
                            if (mem_ready) begin
                                state_nxt   = BUSY_I;
                                busy_we_nxt = 1'b0;
                            end
                        end
                        if (i_gnt) begin
                            starve_nxt = '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_rvalid) begin
                        i_rvalid  = 1'b1;
                        i_rdata   = mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_rvalid) begin
                        d_rvalid  = 1'b1;
                        d_rdata   = busy_we ? '0 : mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                ERR_I: begin
                    i_rvalid  = 1'b1;
                    i_err     = 1'b1;
                    state_nxt = IDLE;
                end
                ERR_D: begin
                    d_rvalid  = 1'b1;
                    d_err     = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model of the arbiter plus a
// small memory device.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic        i_gnt, i_rvalid;
        logic [31:0] i_rdata;
        logic        i_err, d_gnt, d_rvalid;
        logic [31:0] d_rdata;
        logic        d_err, mem_req, mem_we;
        logic [31:0] mem_addr, mem_wdata;
        logic [3:0]  mem_wstrb;
    } outs_t;

    function automatic outs_t sample();
        outs_t o;
        o.i_gnt = i_gnt;     o.i_rvalid = i_rvalid; o.i_rdata = i_rdata; o.i_err = i_err;
        o.d_gnt = d_gnt;     o.d_rvalid = d_rvalid; o.d_rdata = d_rdata; o.d_err = d_err;
        o.mem_req = mem_req; o.mem_we = mem_we;     o.mem_addr = mem_addr;
        o.mem_wdata = mem_wdata; o.mem_wstrb = mem_wstrb;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bundle(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        d_wstrb = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: one request from a freshly reset arbiter,
    // then the memory response (or none) in the following cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic        i_req;  logic [31:0] i_addr;
        logic        d_req;  logic d_we; logic [31:0] d_addr; logic [31:0] d_wdata; logic [3:0] d_wstrb;
        logic        ready;  logic rv;   logic [31:0] rdata;
        logic        e_ign;  logic e_dgn; logic e_mreq; logic e_mwe;
        logic [31:0] e_maddr; logic [31:0] e_mwdata; logic [3:0] e_mwstrb;
        logic        e_irv;  logic e_drv; logic e_ierr; logic e_derr;
        logic [31:0] e_irdata; logic [31:0] e_drdata;
    } vec_t;

    vec_t vt[8];

    // ------------------------------------------------------------------
    // Transaction-level reference model and memory device for random run
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [64];
    logic [31:0] dev_mem [64];
    int          m_owner;      // 0 none, 1 fetch, 2 load/store
    bit          m_err;
    logic [31:0] m_rdata;
    int          m_starve;     // D grants won while I was waiting since I last won
    bit          dev_pend;
    int          dev_cnt;
    logic [31:0] dev_rd;
    bit          i_gnt_seen, d_gnt_seen;

    task automatic model_eval(output outs_t e);
        bit          d_wins, i_wins, taken, mis, we;
        logic [31:0] a;
        e = '0;
        if (m_owner == 0) begin
            d_wins = d_req && !(i_req && m_starve >= STARVE_MAX);
            i_wins = i_req && !d_wins;
            if (d_wins || i_wins) begin
                a     = d_wins ? d_addr : i_addr;
                we    = d_wins && d_we;
                mis   = (a % 4) != 0;
                taken = mis || mem_ready;
                if (!mis) begin
                    e.mem_req   = 1;
                    e.mem_we    = we;
                    e.mem_addr  = a;
                    e.mem_wdata = d_wins ? d_wdata : 32'h0;
                    e.mem_wstrb = d_wins ? d_wstrb : 4'h0;
                end
                if (d_wins) e.d_gnt = taken; else e.i_gnt = taken;
                if (taken) begin
                    m_owner = d_wins ? 2 : 1;
                    m_err   = mis;
                    if (i_wins) m_starve = 0;
                    else if (i_req && m_starve < STARVE_MAX) m_starve++;
                    if (!mis) begin
                        if (we) begin
                            m_rdata = 0;
                            for (int b = 0; b < 4; b++)
                                if (d_wstrb[b]) ref_mem[(a / 4) % 64][8*b +: 8] = d_wdata[8*b +: 8];
                        end else begin
                            m_rdata = ref_mem[(a / 4) % 64];
                        end
                    end
                end
            end
        end else if (m_err) begin
            if (m_owner == 1) begin e.i_rvalid = 1; e.i_err = 1; end
            else              begin e.d_rvalid = 1; e.d_err = 1; end
            m_owner = 0;
        end else if (mem_rvalid) begin
            if (m_owner == 1) begin e.i_rvalid = 1; e.i_rdata = m_rdata; end
            else              begin e.d_rvalid = 1; e.d_rdata = m_rdata; end
            m_owner = 0;
        end
    endtask

    // Memory device: accepts on mem_req&mem_ready, answers 1..3 cycles later
    task automatic device_capture();
        int idx;
        if (mem_req && mem_ready) begin
            idx      = mem_addr[7:2];
            dev_pend = 1;
            dev_cnt  = $urandom_range(1, 3);
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) dev_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                dev_rd = $urandom;
            end else begin
                dev_rd = dev_mem[idx];
            end
        end
    endtask

    task automatic device_drive();
        mem_ready = ($urandom_range(0, 3) != 0);
        mem_rvalid = 0;
        mem_rdata  = $urandom;
        if (dev_pend) begin
            dev_cnt--;
            if (dev_cnt == 0) begin
                mem_rvalid = 1;
                mem_rdata  = dev_rd;
                dev_pend   = 0;
            end
        end else begin
            mem_rvalid = ($urandom_range(0, 7) == 0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return a;
    endfunction

    task automatic requester_drive();
        if (i_gnt_seen) i_req = 0;
        else if (i_req && $urandom_range(0, 15) == 0) i_req = 0;
        else if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req  = 1;
            i_addr = rand_addr();
        end
        if (d_gnt_seen) d_req = 0;
        else if (d_req && $urandom_range(0, 15) == 0) d_req = 0;
        else if (!d_req && $urandom_range(0, 1) == 1) begin
            d_req   = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = rand_addr();
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
        end
    endtask

    initial begin
        outs_t  got, exp;
        string  seq;
        int     n;
        bit     had_gnt;

        //            i_req i_addr        d_req we d_addr        d_wdata       wstrb rdy rv rdata          ign dgn mreq mwe maddr         mwdata        mwstrb irv drv ierr derr irdata        drdata
        vt[0] = '{1, 32'h0000_0100, 0, 0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h0000_0013, 1, 0, 1, 0, 32'h0000_0100, 32'h0,         4'h0, 1, 0, 0, 0, 32'h0000_0013, 32'h0};
        vt[1] = '{0, 32'h0,         1, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 1, 1, 32'h1234_5678, 0, 1, 1, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 0, 32'h0,         32'h0};
        vt[2] = '{0, 32'h0,         1, 0, 32'h0000_0040, 32'h0,         4'h0, 1, 1, 32'hCAFE_F00D, 0, 1, 1, 0, 32'h0000_0040, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0,         32'hCAFE_F00D};
        vt[3] = '{0, 32'h0,         1, 0, 32'h0000_2002, 32'h0,         4'h0, 1, 1, 32'h5555_5555, 0, 1, 0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 0, 1, 32'h0,         32'h0};
        vt[4] = '{1, 32'h0000_0101, 0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'h0000_0077, 1, 0, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 1, 0, 32'h0,         32'h0};
        vt[5] = '{1, 32'h0000_0200, 1, 0, 32'h0000_0300, 32'h0,         4'h0, 1, 1, 32'h0A0B_0C0D, 0, 1, 1, 0, 32'h0000_0300, 32'h0,         4'h0, 0, 1, 0, 0, 32'h0,         32'h0A0B_0C0D};
        vt[6] = '{1, 32'h0000_0104, 0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 32'h0000_0099, 0, 0, 1, 0, 32'h0000_0104, 32'h0,         4'h0, 0, 0, 0, 0, 32'h0,         32'h0};
        vt[7] = '{1, 32'h0000_0200, 1, 1, 32'h0000_0003, 32'h1111_1111, 4'hF, 1, 0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         4'h0, 0, 1, 0, 1, 32'h0,         32'h0};

        // Reset state with requests already pending
        clear_inputs();
        resetn = 0;
        i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200; mem_ready = 1;
        @(negedge clk);
        chk_bundle("reset", sample(), '0);

        // Directed vectors
        for (int k = 0; k < 8; k++) begin
            do_reset();
            i_req = vt[k].i_req; i_addr = vt[k].i_addr;
            d_req = vt[k].d_req; d_we = vt[k].d_we; d_addr = vt[k].d_addr;
            d_wdata = vt[k].d_wdata; d_wstrb = vt[k].d_wstrb; mem_ready = vt[k].ready;
            @(negedge clk);
            chk($sformatf("v%0d.i_gnt", k), 32'(i_gnt), 32'(vt[k].e_ign));
            chk($sformatf("v%0d.d_gnt", k), 32'(d_gnt), 32'(vt[k].e_dgn));
            chk($sformatf("v%0d.mem_req", k), 32'(mem_req), 32'(vt[k].e_mreq));
            chk($sformatf("v%0d.mem_we", k), 32'(mem_we), 32'(vt[k].e_mwe));
            chk($sformatf("v%0d.mem_addr", k), mem_addr, vt[k].e_maddr);
            chk($sformatf("v%0d.mem_wdata", k), mem_wdata, vt[k].e_mwdata);
            chk($sformatf("v%0d.mem_wstrb", k), 32'(mem_wstrb), 32'(vt[k].e_mwstrb));
            @(posedge clk); #1;
            i_req = 0; d_req = 0; mem_ready = 0;
            mem_rvalid = vt[k].rv; mem_rdata = vt[k].rdata;
            @(negedge clk);
            chk($sformatf("v%0d.i_rvalid", k), 32'(i_rvalid), 32'(vt[k].e_irv));
            chk($sformatf("v%0d.d_rvalid", k), 32'(d_rvalid), 32'(vt[k].e_drv));
            chk($sformatf("v%0d.i_err", k), 32'(i_err), 32'(vt[k].e_ierr));
            chk($sformatf("v%0d.d_err", k), 32'(d_err), 32'(vt[k].e_derr));
            chk($sformatf("v%0d.i_rdata", k), i_rdata, vt[k].e_irdata);
            chk($sformatf("v%0d.d_rdata", k), d_rdata, vt[k].e_drdata);
            @(posedge clk); #1;
            mem_rvalid = 0;
        end

        // Backpressure: three cycles without mem_ready, then accepted
        do_reset();
        i_req = 1; i_addr = 32'h180; mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.i_gnt", c), 32'(i_gnt), 32'd0);
            chk($sformatf("bp%0d.mem_req", c), 32'(mem_req), 32'd1);
            chk($sformatf("bp%0d.mem_addr", c), mem_addr, 32'h180);
            @(posedge clk); #1;
        end
        mem_ready = 1;
        @(negedge clk);
        chk("bp.i_gnt", 32'(i_gnt), 32'd1);
        @(posedge clk); #1;
        i_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_00A1;
        @(negedge clk);
        chk("bp.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("bp.i_rdata", i_rdata, 32'h0000_00A1);
        @(posedge clk); #1;
        mem_rvalid = 0;

        // Contention with a one-cycle memory: D wins STARVE_MAX times, then I
        do_reset();
        i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h20; mem_ready = 1;
        seq = "";
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (i_gnt && d_gnt) chk("cont.both_gnt", 32'd1, 32'd0);
            had_gnt = i_gnt || d_gnt;
            if (had_gnt) begin
                seq = {seq, d_gnt ? "D" : "I"};
                n++;
            end
            @(posedge clk); #1;
            mem_rvalid = had_gnt;
        end
        checks++;
        if (seq != "DDDDID") begin
            errors++;
            $display("FAIL contention_order: got %s expected DDDDID", seq);
        end
        do_reset();

        // Reset while a load is outstanding; the late response must be dropped
        d_req = 1; d_addr = 32'h44; mem_ready = 1;
        @(negedge clk);
        chk("rst.d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        d_req = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
        i_req = 1; i_addr = 32'h80;
        resetn = 0;
        #1;
        chk_bundle("rst.async", sample(), '0);
        @(posedge clk); #1;
        resetn = 1; i_req = 0;
        @(negedge clk);
        chk("rst.late_d_rvalid", 32'(d_rvalid), 32'd0);
        chk_bundle("rst.late_idle", sample(), '0);
        @(posedge clk); #1;
        mem_rvalid = 0; i_req = 1; i_addr = 32'h80; mem_ready = 1;
        @(negedge clk);
        chk("rst.i_gnt", 32'(i_gnt), 32'd1);
        chk("rst.mem_addr", mem_addr, 32'h80);
        @(posedge clk); #1;
        i_req = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_1111;
        @(negedge clk);
        chk("rst.i_rvalid", 32'(i_rvalid), 32'd1);
        chk("rst.i_rdata", i_rdata, 32'h0000_1111);
        @(posedge clk); #1;
        mem_rvalid = 0;

        // Randomized run against the reference model
        for (int w = 0; w < 64; w++) begin
            ref_mem[w] = $urandom;
            dev_mem[w] = ref_mem[w];
        end
        do_reset();
        m_owner = 0; m_err = 0; m_rdata = 0; m_starve = 0;
        dev_pend = 0; dev_cnt = 0; dev_rd = 0;
        i_gnt_seen = 0; d_gnt_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            device_drive();
            requester_drive();
            @(negedge clk);
            got = sample();
            model_eval(exp);
            chk_bundle("random", got, exp);
            device_capture();
            i_gnt_seen = got.i_gnt;
            d_gnt_seen = got.d_gnt;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
